// File: rtl/lms_coef_update_seq_if.sv
// rtl/lms_coef_update_seq_if.sv - request/coefficient bus for the LMS coefficient updater
interface lms_coef_update_seq_if #(
    parameter int N_TAPS  = 3,
    parameter int NB_DATA = 32
);
    logic                        i_valid;
    logic                        o_ready;
    logic [NB_DATA-1:0]          i_error;
    logic [NB_DATA-1:0]          i_mu;
    logic [N_TAPS*NB_DATA-1:0]   i_x;
    logic                        i_freeze;
    logic                        i_clear;
    logic                        o_done;
    logic [N_TAPS*NB_DATA-1:0]   o_h;

    modport master (
        output i_valid, i_error, i_mu, i_x, i_freeze, i_clear,
        input  o_ready, o_done, o_h
    );

    modport slave (
        input  i_valid, i_error, i_mu, i_x, i_freeze, i_clear,
        output o_ready, o_done, o_h
    );
endinterface

// File: rtl/lms_coef_update_seq.sv
// rtl/lms_coef_update_seq.sv - N-tap LMS coefficient updater, one shared multiplier walked across taps
// Optional leakage term h >>> LEAK_SHIFT is built only when LMS_LEAKAGE_EN is defined.
module lms_coef_update_seq #(
    parameter int N_TAPS     = 3,
    parameter int NB_DATA    = 32,
    parameter int NBF_DATA   = 16,
    parameter int LEAK_SHIFT = 10
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    lms_coef_update_seq_if.slave  bus
);

    localparam int IDX_W = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
    localparam int NW    = 2 * NB_DATA;

    typedef logic signed [NB_DATA-1:0] word_t;
    typedef logic signed [NW-1:0]      wide_t;

    localparam word_t W_MAX = {1'b0, {(NB_DATA-1){1'b1}}};
    localparam word_t W_MIN = {1'b1, {(NB_DATA-1){1'b0}}};
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_TAPS - 1);

    generate
        if (N_TAPS < 1 || NBF_DATA >= NB_DATA || LEAK_SHIFT < 0 || LEAK_SHIFT >= NB_DATA) begin : g_param_check
            $error("lms_coef_update_seq: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUE,
        S_UPD,
        S_DONE
    } state_t;

    function automatic wide_t sext(input word_t a);
        return {{NB_DATA{a[NB_DATA-1]}}, a};
    endfunction

    // In range when every bit above the word's sign bit agrees with it.
    function automatic word_t sat_w(input wide_t v);
        logic [NB_DATA:0] top;
        top = v[NW-1:NB_DATA-1];
        if ((&top) || !(|top)) begin
            return v[NB_DATA-1:0];
        end else if (v[NW-1]) begin
            return W_MIN;
        end else begin
            return W_MAX;
        end
    endfunction

    // Full 2*NB product, floor-drop the extra fraction bits, clamp back to a word.
    function automatic word_t mul_sat(input word_t a, input word_t b);
        wide_t p;
        p = sext(a) * sext(b);
        return sat_w(p >>> NBF_DATA);
    endfunction

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    word_t            e_q, mu_q, ue_q;
    logic             frz_q;
    word_t            x_q [N_TAPS];
    word_t            h_q [N_TAPS];

    logic             accept;
    word_t            h_sel;
    word_t            tap_prod;
    wide_t            sum_w;
    word_t            h_new;

    always_comb begin
        accept  = 1'b0;
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                accept = bus.i_valid && !bus.i_clear;
                if (accept) begin
                    state_d = S_MUE;
                    idx_d   = '0;
                end
            end
            S_MUE: begin
                state_d = S_UPD;
                idx_d   = '0;
            end
            S_UPD: begin
                if (idx_q == IDX_LAST) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase
        // Clear aborts any cycle in flight, so no o_done follows it.
        if (bus.i_clear) begin
            state_d = S_IDLE;
            idx_d   = '0;
        end
    end

    always_comb begin
        h_sel    = h_q[idx_q];
        tap_prod = mul_sat(ue_q, x_q[idx_q]);
`ifdef LMS_LEAKAGE_EN
        sum_w    = sext(h_sel) - sext(h_sel >>> LEAK_SHIFT) + sext(tap_prod);
`else
        sum_w    = sext(h_sel) + sext(tap_prod);
`endif
        h_new    = sat_w(sum_w);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            e_q     <= '0;
            mu_q    <= '0;
            ue_q    <= '0;
            frz_q   <= 1'b0;
            for (int k = 0; k < N_TAPS; k++) begin
                x_q[k] <= '0;
                h_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (accept) begin
                e_q   <= bus.i_error;
                mu_q  <= bus.i_mu;
                frz_q <= bus.i_freeze;
                for (int k = 0; k < N_TAPS; k++) begin
                    x_q[k] <= bus.i_x[k*NB_DATA +: NB_DATA];
                end
            end
            if (state_q == S_MUE) begin
                ue_q <= mul_sat(e_q, mu_q);
            end
            if (bus.i_clear) begin
                for (int k = 0; k < N_TAPS; k++) begin
                    h_q[k] <= '0;
                end
            end else if (state_q == S_UPD && !frz_q) begin
                h_q[idx_q] <= h_new;
            end
        end
    end

    assign bus.o_ready = (state_q == S_IDLE);
    assign bus.o_done  = (state_q == S_DONE);

    generate
        for (genvar g = 0; g < N_TAPS; g++) begin : g_out
            assign bus.o_h[g*NB_DATA +: NB_DATA] = h_q[g];
        end
    endgenerate

endmodule

// File: tb/tb_lms_coef_update_seq.sv
// tb/tb_lms_coef_update_seq.sv - directed self-checking bench for lms_coef_update_seq
module tb_lms_coef_update_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    lms_coef_update_seq_if #(.N_TAPS(3), .NB_DATA(32)) bus ();

    lms_coef_update_seq #(
        .N_TAPS(3), .NB_DATA(32), .NBF_DATA(16), .LEAK_SHIFT(10)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    localparam logic [31:0] ONE = 32'h0001_0000;

    task automatic run_update(input logic [31:0] e, input logic [31:0] mu,
                              input logic [95:0] x, input logic frz, output int done_cyc);
        bus.i_error  = e;
        bus.i_mu     = mu;
        bus.i_x      = x;
        bus.i_freeze = frz;
        bus.i_valid  = 1'b1;
        @(posedge clk); #1;
        bus.i_valid  = 1'b0;
        bus.i_error  = 32'hDEAD_BEEF;
        bus.i_mu     = 32'h7FFF_FFFF;
        bus.i_x      = {3{32'h5A5A_5A5A}};
        bus.i_freeze = ~frz;
        done_cyc = -1;
        for (int c = 1; c <= 20; c++) begin
            if (bus.o_done) begin
                done_cyc = c;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic pulse_clear();
        bus.i_clear = 1'b1;
        @(posedge clk); #1;
        bus.i_clear = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (bus.o_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", bus.o_ready); end
        n_cmp++; if (bus.o_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", bus.o_done); end
        n_cmp++; if (bus.o_h !== 96'h0) begin n_err++; $display("FAIL reset_h: got %h expected 0", bus.o_h); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int dc;
        run_update(ONE, 32'h0001_8000, {32'hFFFF_0000, 32'h0, ONE}, 1'b0, dc);
        n_cmp++; if (dc !== 5) begin n_err++; $display("FAIL basic_done_cycle: got %0d expected 5", dc); end
        n_cmp++; if (bus.o_h !== {32'hFFFE_8000, 32'h0, 32'h0001_8000}) begin n_err++; $display("FAIL basic_h: got %h expected fffe8000_00000000_00018000", bus.o_h); end
        n_cmp++; if (bus.o_ready !== 1'b1) begin n_err++; $display("FAIL basic_ready_after: got %b expected 1", bus.o_ready); end
    endtask

    task automatic test_clear_abort();
        int nd;
        bus.i_error = ONE; bus.i_mu = 32'h0001_8000; bus.i_x = {32'hFFFF_0000, 32'h0, ONE};
        bus.i_valid = 1'b1;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.i_clear = 1'b1;
        @(posedge clk); #1;
        bus.i_clear = 1'b0;
        n_cmp++; if (bus.o_ready !== 1'b1) begin n_err++; $display("FAIL clear_ready: got %b expected 1", bus.o_ready); end
        n_cmp++; if (bus.o_h !== 96'h0) begin n_err++; $display("FAIL clear_h: got %h expected 0", bus.o_h); end
        nd = 0;
        for (int c = 0; c < 8; c++) begin
            if (bus.o_done) nd++;
            @(posedge clk); #1;
        end
        n_cmp++; if (nd !== 0) begin n_err++; $display("FAIL clear_no_done: got %0d pulses expected 0", nd); end
    endtask

    task automatic test_saturation();
        int dc;
        run_update(ONE, ONE, {32'h0, 32'h0, 32'h7FFF_0000}, 1'b0, dc);
        n_cmp++; if (bus.o_h[31:0] !== 32'h7FFF_0000) begin n_err++; $display("FAIL sat_preload_pos: got %h expected 7fff0000", bus.o_h[31:0]); end
        run_update(ONE, ONE, {32'h0, 32'h0, ONE}, 1'b0, dc);
        n_cmp++; if (bus.o_h[31:0] !== 32'h7FFF_FFFF) begin n_err++; $display("FAIL sat_pos: got %h expected 7fffffff", bus.o_h[31:0]); end
        pulse_clear();
        run_update(ONE, ONE, {32'h0, 32'h0, 32'h8001_0000}, 1'b0, dc);
        n_cmp++; if (bus.o_h[31:0] !== 32'h8001_0000) begin n_err++; $display("FAIL sat_preload_neg: got %h expected 80010000", bus.o_h[31:0]); end
        run_update(ONE, ONE, {32'h0, 32'h0, 32'hFFFE_0000}, 1'b0, dc);
        n_cmp++; if (bus.o_h[31:0] !== 32'h8000_0000) begin n_err++; $display("FAIL sat_neg: got %h expected 80000000", bus.o_h[31:0]); end
        pulse_clear();
        run_update(32'h7FFF_0000, 32'h7FFF_0000, {32'h0, 32'hFFFF_0000, ONE}, 1'b0, dc);
        n_cmp++; if (bus.o_h !== {32'h0, 32'h8000_0001, 32'h7FFF_FFFF}) begin n_err++; $display("FAIL sat_mue: got %h expected 00000000_80000001_7fffffff", bus.o_h); end
    endtask

    task automatic test_floor();
        int dc;
        pulse_clear();
        run_update(ONE, 32'h0000_0001, {32'h0, 32'h0001_8000, 32'h0000_8000}, 1'b0, dc);
        n_cmp++; if (bus.o_h !== {32'h0, 32'h0000_0001, 32'h0}) begin n_err++; $display("FAIL floor_pos_half: got %h expected 00000000_00000001_00000000", bus.o_h); end
        run_update(ONE, 32'h0000_0001, {32'h0, 32'h0, 32'hFFFF_8000}, 1'b0, dc);
        n_cmp++; if (bus.o_h !== {32'h0, 32'h0000_0001, 32'hFFFF_FFFF}) begin n_err++; $display("FAIL floor_neg_half: got %h expected 00000000_00000001_ffffffff", bus.o_h); end
    endtask

    task automatic test_back_to_back();
        int nd;
        int first;
        int last;
        pulse_clear();
        bus.i_error = ONE; bus.i_mu = ONE; bus.i_x = {32'h0, 32'h0, 32'h1}; bus.i_freeze = 1'b0;
        bus.i_valid = 1'b1;
        nd = 0; first = -1; last = -1;
        for (int c = 1; c <= 24; c++) begin
            @(posedge clk); #1;
            if (bus.o_done) begin
                if (last >= 0) begin
                    n_cmp++; if (c - last !== 6) begin n_err++; $display("FAIL b2b_period: got %0d expected 6", c - last); end
                end else begin
                    first = c;
                end
                nd++;
                last = c;
            end
        end
        bus.i_valid = 1'b0;
        n_cmp++; if (first !== 5) begin n_err++; $display("FAIL b2b_first_done: got %0d expected 5", first); end
        n_cmp++; if (nd !== 4) begin n_err++; $display("FAIL b2b_count: got %0d expected 4", nd); end
        repeat (2) begin @(posedge clk); #1; end
        n_cmp++; if (bus.o_h[31:0] !== 32'h0000_0004) begin n_err++; $display("FAIL b2b_h0: got %h expected 00000004", bus.o_h[31:0]); end
        n_cmp++; if (bus.o_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready: got %b expected 1", bus.o_ready); end
    endtask

    task automatic test_freeze();
        int dc;
        run_update(ONE, ONE, {ONE, ONE, ONE}, 1'b1, dc);
        n_cmp++; if (dc !== 5) begin n_err++; $display("FAIL freeze_done_cycle: got %0d expected 5", dc); end
        n_cmp++; if (bus.o_h !== {32'h0, 32'h0, 32'h0000_0004}) begin n_err++; $display("FAIL freeze_h: got %h expected 00000000_00000000_00000004", bus.o_h); end
    endtask

    task automatic test_clear_wins();
        int nd;
        bus.i_error = ONE; bus.i_mu = ONE; bus.i_x = {ONE, ONE, ONE}; bus.i_freeze = 1'b0;
        bus.i_valid = 1'b1;
        bus.i_clear = 1'b1;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        bus.i_clear = 1'b0;
        n_cmp++; if (bus.o_ready !== 1'b1) begin n_err++; $display("FAIL clrwin_ready: got %b expected 1", bus.o_ready); end
        n_cmp++; if (bus.o_h !== 96'h0) begin n_err++; $display("FAIL clrwin_h: got %h expected 0", bus.o_h); end
        nd = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (bus.o_done) nd++;
        end
        n_cmp++; if (nd !== 0) begin n_err++; $display("FAIL clrwin_no_done: got %0d pulses expected 0", nd); end
        n_cmp++; if (bus.o_h !== 96'h0) begin n_err++; $display("FAIL clrwin_h_later: got %h expected 0", bus.o_h); end
    endtask

    task automatic test_async_reset();
        int dc;
        run_update(ONE, ONE, {ONE, ONE, ONE}, 1'b0, dc);
        n_cmp++; if (bus.o_h !== {ONE, ONE, ONE}) begin n_err++; $display("FAIL arst_preload: got %h expected 00010000 x3", bus.o_h); end
        bus.i_valid = 1'b1;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.o_ready !== 1'b1) begin n_err++; $display("FAIL arst_ready: got %b expected 1", bus.o_ready); end
        n_cmp++; if (bus.o_done !== 1'b0) begin n_err++; $display("FAIL arst_done: got %b expected 0", bus.o_done); end
        n_cmp++; if (bus.o_h !== 96'h0) begin n_err++; $display("FAIL arst_h: got %h expected 0", bus.o_h); end
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            n_cmp++; if (bus.o_done !== 1'b0) begin n_err++; $display("FAIL arst_stale_done: got %b expected 0", bus.o_done); end
        end
        n_cmp++; if (bus.o_h !== 96'h0) begin n_err++; $display("FAIL arst_h_after: got %h expected 0", bus.o_h); end
    endtask

`ifdef LMS_LEAKAGE_EN
    task automatic test_leakage();
        int dc;
        pulse_clear();
        run_update(ONE, ONE, {32'h0, 32'h0, 32'h0400_0000}, 1'b0, dc);
        n_cmp++; if (bus.o_h[31:0] !== 32'h0400_0000) begin n_err++; $display("FAIL leak_preload: got %h expected 04000000", bus.o_h[31:0]); end
        run_update(32'h0, ONE, {32'h0, 32'h0, 32'h0}, 1'b0, dc);
        n_cmp++; if (bus.o_h[31:0] !== 32'h03FF_0000) begin n_err++; $display("FAIL leak_h0: got %h expected 03ff0000", bus.o_h[31:0]); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_valid  = 1'b0;
        bus.i_error  = '0;
        bus.i_mu     = '0;
        bus.i_x      = '0;
        bus.i_freeze = 1'b0;
        bus.i_clear  = 1'b0;
        test_reset();
        test_basic();
        test_clear_abort();
        test_saturation();
        test_floor();
        test_back_to_back();
        test_freeze();
        test_clear_wins();
        test_async_reset();
`ifdef LMS_LEAKAGE_EN
        test_leakage();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
